// File: rtl/tx_ordered_set_encode_pkg.sv
// Shared definitions for the transmit ordered-set encoder: widths, FSM states,
// 8B octet values and the 10B RD-/RD+ code-group table for every supported K and D.
package tx_ordered_set_encode_pkg;

  localparam int CG_WIDTH    = 10;
  localparam int OCTET_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE_K = 3'd0,
    IDLE_D = 3'd1,
    DATA   = 3'd2,
    EXT1   = 3'd3,
    EXT2   = 3'd4
  } state_e;

  localparam logic [OCTET_WIDTH-1:0] K28_5_8B = 8'hBC;
  localparam logic [OCTET_WIDTH-1:0] K23_7_8B = 8'hF7;
  localparam logic [OCTET_WIDTH-1:0] K27_7_8B = 8'hFB;
  localparam logic [OCTET_WIDTH-1:0] K29_7_8B = 8'hFD;
  localparam logic [OCTET_WIDTH-1:0] D5_6_8B  = 8'hC5;
  localparam logic [OCTET_WIDTH-1:0] D16_2_8B = 8'h50;

  // Code-groups are written abcdei_fghj with 'a' in bit 9.
  localparam logic [CG_WIDTH-1:0] K28_5_10B_RD_N = 10'b001111_1010;
  localparam logic [CG_WIDTH-1:0] K28_5_10B_RD_P = 10'b110000_0101;
  localparam logic [CG_WIDTH-1:0] K23_7_10B_RD_N = 10'b111010_1000;
  localparam logic [CG_WIDTH-1:0] K23_7_10B_RD_P = 10'b000101_0111;
  localparam logic [CG_WIDTH-1:0] K27_7_10B_RD_N = 10'b110110_1000;
  localparam logic [CG_WIDTH-1:0] K27_7_10B_RD_P = 10'b001001_0111;
  localparam logic [CG_WIDTH-1:0] K29_7_10B_RD_N = 10'b101110_1000;
  localparam logic [CG_WIDTH-1:0] K29_7_10B_RD_P = 10'b010001_0111;
  localparam logic [CG_WIDTH-1:0] D0_0_10B_RD_N  = 10'b100111_0100;
  localparam logic [CG_WIDTH-1:0] D0_0_10B_RD_P  = 10'b011000_1011;

  typedef struct packed {
    logic                hit;
    logic [CG_WIDTH-1:0] rd_n;
    logic [CG_WIDTH-1:0] rd_p;
  } cg_pair_t;

  // SUPPORTED check list for data octets; a miss falls back to D0.0.
  function automatic cg_pair_t supported_d(input logic [OCTET_WIDTH-1:0] octet);
    cg_pair_t p;
    p = '{hit: 1'b0, rd_n: D0_0_10B_RD_N, rd_p: D0_0_10B_RD_P};
    case (octet)
      8'h00: p = '{1'b1, 10'b100111_0100, 10'b011000_1011};  // D0.0
      8'h01: p = '{1'b1, 10'b011101_0100, 10'b100010_1011};  // D1.0
      8'h02: p = '{1'b1, 10'b101101_0100, 10'b010010_1011};  // D2.0
      8'h42: p = '{1'b1, 10'b101101_0101, 10'b010010_0101};  // D2.2
      8'hC3: p = '{1'b1, 10'b110001_0110, 10'b110001_0110};  // D3.6
      8'hC4: p = '{1'b1, 10'b110101_0110, 10'b001010_0110};  // D4.6
      8'hC5: p = '{1'b1, 10'b101001_0110, 10'b101001_0110};  // D5.6
      8'h87: p = '{1'b1, 10'b111000_1101, 10'b000111_0010};  // D7.4
      8'hC8: p = '{1'b1, 10'b111001_0110, 10'b000110_0110};  // D8.6
      8'h2A: p = '{1'b1, 10'b010101_1001, 10'b010101_1001};  // D10.1
      8'h6B: p = '{1'b1, 10'b110100_1100, 10'b110100_0011};  // D11.3
      8'hAC: p = '{1'b1, 10'b001101_1010, 10'b001101_1010};  // D12.5
      8'h50: p = '{1'b1, 10'b011011_0101, 10'b100100_0101};  // D16.2
      8'h53: p = '{1'b1, 10'b110010_0101, 10'b110010_0101};  // D19.2
      8'hB5: p = '{1'b1, 10'b101010_1010, 10'b101010_1010};  // D21.5
      8'h37: p = '{1'b1, 10'b111010_1001, 10'b000101_1001};  // D23.1
      8'h78: p = '{1'b1, 10'b110011_0011, 10'b001100_1100};  // D24.3
      8'hBC: p = '{1'b1, 10'b001110_1010, 10'b001110_1010};  // D28.5
      8'h7D: p = '{1'b1, 10'b101110_0011, 10'b010001_1100};  // D29.3
      8'h3F: p = '{1'b1, 10'b101011_1001, 10'b010100_1001};  // D31.1
      default: ;
    endcase
    return p;
  endfunction

  function automatic cg_pair_t supported_k(input logic [OCTET_WIDTH-1:0] octet);
    cg_pair_t p;
    p = '{hit: 1'b0, rd_n: D0_0_10B_RD_N, rd_p: D0_0_10B_RD_P};
    case (octet)
      K28_5_8B: p = '{1'b1, K28_5_10B_RD_N, K28_5_10B_RD_P};
      K23_7_8B: p = '{1'b1, K23_7_10B_RD_N, K23_7_10B_RD_P};
      K27_7_8B: p = '{1'b1, K27_7_10B_RD_N, K27_7_10B_RD_P};
      K29_7_8B: p = '{1'b1, K29_7_10B_RD_N, K29_7_10B_RD_P};
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tx_ordered_set_encode_if.sv
// GMII-side inputs and SUDI-side code-group outputs of the transmit encoder.
interface tx_ordered_set_encode_if;
  import tx_ordered_set_encode_pkg::*;

  logic                   tx_en;
  logic [OCTET_WIDTH-1:0] txd;
  logic [CG_WIDTH-1:0]    tx_code_group;
  logic                   tx_cg_valid;
  logic                   tx_even;
  logic                   tx_running_disparity;
  logic                   tx_encode_err;

  modport master (
    output tx_en, txd,
    input  tx_code_group, tx_cg_valid, tx_even, tx_running_disparity, tx_encode_err
  );

  modport slave (
    input  tx_en, txd,
    output tx_code_group, tx_cg_valid, tx_even, tx_running_disparity, tx_encode_err
  );
endinterface

// File: rtl/tx_ordered_set_encode_8b10b.sv
// Combinational 8B/10B encoder for the supported K and D code-groups; the exact
// inverse of the receive decode table. Unsupported octets map to D0.0 with err.
module tx_ordered_set_encode_8b10b
  import tx_ordered_set_encode_pkg::*;
(
  input  logic [OCTET_WIDTH-1:0] octet,
  input  logic                   is_k,
  input  logic                   rd,
  output logic [CG_WIDTH-1:0]    code_group,
  output logic                   rd_next,
  output logic                   err
);

  cg_pair_t   pair;
  logic [3:0] ones;

  always_comb begin
    pair       = is_k ? supported_k(octet) : supported_d(octet);
    err        = ~pair.hit;
    code_group = rd ? pair.rd_p : pair.rd_n;
    ones       = '0;
    for (int i = 0; i < CG_WIDTH; i++) begin
      ones = ones + {3'b000, code_group[i]};
    end
    // Only a 6/4 split moves the running disparity.
    rd_next = rd ^ (ones != 4'd5);
  end

endmodule

// File: rtl/tx_ordered_set_encode.sv
// Transmit PCS ordered-set encoder: frames GMII octets with /S/ /T/ /R/ and idles,
// tracking running disparity and even/odd slot alignment; one code-group per clock.
module tx_ordered_set_encode
  import tx_ordered_set_encode_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  tx_ordered_set_encode_if.slave bus
);

  state_e                 state_q, state_d;
  logic                   slot_even_q;
  logic [CG_WIDTH-1:0]    cg_q;
  logic                   valid_q;
  logic                   even_q;
  logic                   rd_q;
  logic                   err_q;

  logic [OCTET_WIDTH-1:0] enc_octet;
  logic                   enc_is_k;
  logic [CG_WIDTH-1:0]    enc_cg;
  logic                   enc_rd_next;
  logic                   enc_err;
  logic                   err_d;

  tx_ordered_set_encode_8b10b u_encode_8b10b (
    .octet      (enc_octet),
    .is_k       (enc_is_k),
    .rd         (rd_q),
    .code_group (enc_cg),
    .rd_next    (enc_rd_next),
    .err        (enc_err)
  );

  always_comb begin
    state_d   = state_q;
    enc_octet = K28_5_8B;
    enc_is_k  = 1'b1;
    err_d     = 1'b0;
    case (state_q)
      IDLE_K: begin
        if (bus.tx_en) begin
          enc_octet = K27_7_8B;
          state_d   = DATA;
        end else begin
          enc_octet = K28_5_8B;
          state_d   = IDLE_D;
        end
      end
      IDLE_D: begin
        // D16.2 pulls a positive RD back to negative; D5.6 keeps it negative.
        enc_is_k  = 1'b0;
        enc_octet = rd_q ? D16_2_8B : D5_6_8B;
        state_d   = IDLE_K;
      end
      DATA: begin
        if (bus.tx_en) begin
          enc_is_k  = 1'b0;
          enc_octet = bus.txd;
          err_d     = enc_err;
        end else begin
          enc_octet = K29_7_8B;
          state_d   = EXT1;
        end
      end
      EXT1: begin
        enc_octet = K23_7_8B;
        state_d   = slot_even_q ? EXT2 : IDLE_K;
      end
      EXT2: begin
        enc_octet = K23_7_8B;
        state_d   = IDLE_K;
      end
      default: state_d = IDLE_K;
    endcase
  end

  // slot_even_q is the parity of the slot being produced this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_K;
      slot_even_q <= 1'b1;
      cg_q        <= '0;
      valid_q     <= 1'b0;
      even_q      <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_even_q <= ~slot_even_q;
      cg_q        <= enc_cg;
      valid_q     <= 1'b1;
      even_q      <= slot_even_q;
      rd_q        <= enc_rd_next;
      err_q       <= err_d;
    end
  end

  assign bus.tx_code_group        = cg_q;
  assign bus.tx_cg_valid          = valid_q;
  assign bus.tx_even              = even_q;
  assign bus.tx_running_disparity = rd_q;
  assign bus.tx_encode_err        = err_q;

endmodule

// File: tb/tb_tx_ordered_set_encode.sv
// Scoreboard bench for tx_ordered_set_encode: a sub-block 8B/10B reference model
// pushes the expected code-group per driven cycle; each DUT output is popped and compared.
module tb_tx_ordered_set_encode;

  logic clk;
  logic rst_n;

  tx_ordered_set_encode_if bus_if ();

  tx_ordered_set_encode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_IDLE_K, M_IDLE_D, M_DATA, M_EXT1, M_EXT2} m_state_e;

  typedef struct packed {
    logic [9:0] cg;
    logic       even;
    logic       rd;
    logic       err;
  } exp_t;

  localparam logic [9:0] K28_5_N = 10'b001111_1010;
  localparam logic [9:0] K23_7_N = 10'b111010_1000;
  localparam logic [9:0] K27_7_N = 10'b110110_1000;
  localparam logic [9:0] K29_7_N = 10'b101110_1000;

  logic [7:0] supported_list [20] = '{8'h00, 8'h01, 8'h02, 8'h42, 8'hC3, 8'hC4, 8'hC5,
                                      8'h87, 8'hC8, 8'h2A, 8'h6B, 8'hAC, 8'h50, 8'h53,
                                      8'hB5, 8'h37, 8'h78, 8'hBC, 8'h7D, 8'h3F};
  logic [7:0] pkt_a [12] = '{8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hB5, 8'hBC,
                             8'h00, 8'h42, 8'h3F, 8'h42};
  logic [7:0] pkt_b [14] = '{8'h01, 8'h02, 8'hC3, 8'hC4, 8'h87, 8'hC8, 8'h2A, 8'h6B,
                             8'hAC, 8'h50, 8'h53, 8'h37, 8'h78, 8'h7D};
  logic [7:0] pkt_c [9]  = '{8'h00, 8'h42, 8'hFF, 8'h37, 8'h21, 8'hD5, 8'h55, 8'h3F, 8'hC5};

  exp_t     sb_q [$];
  m_state_e m_state;
  logic     m_even;
  logic     m_rd;
  int       n_checks;
  int       n_fail;
  int       n_cycle;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, n_cycle);
    end
  endtask

  function automatic logic [9:0] model_k(input logic [9:0] k_rd_n, input logic rd);
    return rd ? ~k_rd_n : k_rd_n;
  endfunction

  // Sub-block 5B/6B + 3B/4B encoding with the intermediate disparity.
  function automatic logic [9:0] model_encode_d(input logic [7:0] oct, input logic rd);
    logic [5:0] six;
    logic [3:0] four;
    logic       rd_mid;
    case (oct[4:0])
      5'd0:  six = 6'b100111;
      5'd1:  six = 6'b011101;
      5'd2:  six = 6'b101101;
      5'd3:  six = 6'b110001;
      5'd4:  six = 6'b110101;
      5'd5:  six = 6'b101001;
      5'd7:  six = 6'b111000;
      5'd8:  six = 6'b111001;
      5'd10: six = 6'b010101;
      5'd11: six = 6'b110100;
      5'd12: six = 6'b001101;
      5'd16: six = 6'b011011;
      5'd19: six = 6'b110010;
      5'd21: six = 6'b101010;
      5'd23: six = 6'b111010;
      5'd24: six = 6'b110011;
      5'd28: six = 6'b001110;
      5'd29: six = 6'b101110;
      5'd31: six = 6'b101011;
      default: six = 6'b100111;
    endcase
    if (rd && (($countones(six) != 3) || oct[4:0] == 5'd7)) six = ~six;
    rd_mid = rd ^ ($countones(six) != 3);
    case (oct[7:5])
      3'd0: four = 4'b1011;
      3'd1: four = 4'b1001;
      3'd2: four = 4'b0101;
      3'd3: four = 4'b1100;
      3'd4: four = 4'b1101;
      3'd5: four = 4'b1010;
      3'd6: four = 4'b0110;
      default: four = 4'b1110;
    endcase
    if (rd_mid && (($countones(four) != 2) || oct[7:5] == 3'd3)) four = ~four;
    return {six, four};
  endfunction

  function automatic logic is_supported(input logic [7:0] oct);
    for (int i = 0; i < 20; i++) begin
      if (supported_list[i] == oct) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE_K;
    m_even  = 1'b1;
    m_rd    = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic en, input logic [7:0] d);
    exp_t       e;
    logic [9:0] cg;
    logic       err;
    err = 1'b0;
    cg  = '0;
    case (m_state)
      M_IDLE_K: begin
        if (en) begin
          cg = model_k(K27_7_N, m_rd);
          m_state = M_DATA;
        end else begin
          cg = model_k(K28_5_N, m_rd);
          m_state = M_IDLE_D;
        end
      end
      M_IDLE_D: begin
        cg = m_rd ? model_encode_d(8'h50, m_rd) : model_encode_d(8'hC5, m_rd);
        m_state = M_IDLE_K;
      end
      M_DATA: begin
        if (en) begin
          err = ~is_supported(d);
          cg  = err ? model_encode_d(8'h00, m_rd) : model_encode_d(d, m_rd);
        end else begin
          cg = model_k(K29_7_N, m_rd);
          m_state = M_EXT1;
        end
      end
      M_EXT1: begin
        cg = model_k(K23_7_N, m_rd);
        m_state = m_even ? M_EXT2 : M_IDLE_K;
      end
      default: begin
        cg = model_k(K23_7_N, m_rd);
        m_state = M_IDLE_K;
      end
    endcase
    e.cg   = cg;
    e.even = m_even;
    e.err  = err;
    m_rd   = m_rd ^ ($countones(cg) != 5);
    e.rd   = m_rd;
    m_even = ~m_even;
    sb_q.push_back(e);
  endtask

  task automatic run_cycle(input logic en, input logic [7:0] d);
    exp_t e;
    bus_if.tx_en = en;
    bus_if.txd   = d;
    model_step(en, d);
    @(posedge clk);
    #1;
    n_cycle++;
    $display("cyc=%0d en=%b txd=%02h cg=%03h valid=%b even=%b rd=%b err=%b", n_cycle, en, d,
             bus_if.tx_code_group, bus_if.tx_cg_valid, bus_if.tx_even,
             bus_if.tx_running_disparity, bus_if.tx_encode_err);
    if (sb_q.size() == 0) begin
      check_value("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_value("code_group", {22'd0, bus_if.tx_code_group}, {22'd0, e.cg});
      check_value("cg_valid", {31'd0, bus_if.tx_cg_valid}, 32'd1);
      check_value("even", {31'd0, bus_if.tx_even}, {31'd0, e.even});
      check_value("running_disparity", {31'd0, bus_if.tx_running_disparity}, {31'd0, e.rd});
      check_value("encode_err", {31'd0, bus_if.tx_encode_err}, {31'd0, e.err});
    end
    if (bus_if.tx_code_group == K28_5_N || bus_if.tx_code_group == ~K28_5_N ||
        bus_if.tx_code_group == K27_7_N || bus_if.tx_code_group == ~K27_7_N) begin
      check_value("k28_5_or_s_on_even", {31'd0, bus_if.tx_even}, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_code_group"}, {22'd0, bus_if.tx_code_group}, 32'd0);
    check_value({tag, "_valid"}, {31'd0, bus_if.tx_cg_valid}, 32'd0);
    check_value({tag, "_even"}, {31'd0, bus_if.tx_even}, 32'd0);
    check_value({tag, "_rd"}, {31'd0, bus_if.tx_running_disparity}, 32'd0);
    check_value({tag, "_err"}, {31'd0, bus_if.tx_encode_err}, 32'd0);
  endtask

  task automatic idle_until(input m_state_e target);
    for (int i = 0; i < 8 && m_state != target; i++) run_cycle(1'b0, 8'h00);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    n_cycle      = 0;
    rst_n        = 1'b0;
    bus_if.tx_en = 1'b0;
    bus_if.txd   = 8'h00;
    model_reset();

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Idle pairs from RD-, then a packet entered on an even slot
    repeat (8) run_cycle(1'b0, 8'h00);
    idle_until(M_IDLE_K);
    foreach (pkt_a[i]) run_cycle(1'b1, pkt_a[i]);
    repeat (6) run_cycle(1'b0, 8'h00);

    // tx_en rising on the odd (D-idle) slot; a late tx_en during /R/ is ignored
    idle_until(M_IDLE_D);
    foreach (pkt_b[i]) run_cycle(1'b1, pkt_b[i]);
    run_cycle(1'b0, 8'h00);
    run_cycle(1'b1, 8'hB5);
    repeat (5) run_cycle(1'b0, 8'h00);

    // Unsupported octets mid-packet, then a packet that ends with RD+
    idle_until(M_IDLE_K);
    foreach (pkt_c[i]) run_cycle(1'b1, pkt_c[i]);
    repeat (6) run_cycle(1'b0, 8'h00);
    idle_until(M_IDLE_K);
    run_cycle(1'b1, 8'h00);
    run_cycle(1'b1, 8'h42);
    repeat (7) run_cycle(1'b0, 8'h00);

    // Asynchronous reset in the middle of DATA
    idle_until(M_IDLE_K);
    repeat (4) run_cycle(1'b1, 8'hB5);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bus_if.tx_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) run_cycle(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
